// File: rtl/checker_mode_engine_pkg.sv
// Shared definitions for the checker mode engine: mode codes, FSM state
// encodings, datapath widths and the latched command payload.
package checker_mode_engine_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [MODE_W-1:0] {
        CHECKER_MODE_NONE  = 2'd0,
        CHECKER_MODE_DUMMY = 2'd1,
        CHECKER_MODE_READ  = 2'd2,
        CHECKER_MODE_IRQ   = 2'd3
    } checker_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DUMMY    = 3'd1,
        ST_RD_REQ   = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_IRQ_WAIT = 3'd4,
        ST_DONE     = 3'd5
    } checker_state_e;

    // Command captured on the start edge.
    typedef struct packed {
        checker_mode_e     mode;
        logic [ADDR_W-1:0] addr;
    } mode_cmd_t;

endpackage

// File: rtl/checker_mode_engine_if.sv
// Checker mode control bus plus the 64-bit request/acknowledge read port.
// master: control side and memory responder (drives mode_*, mem_ack/data/err)
// slave : checker_mode_engine (drives results, irq and mem_req/mem_addr)
interface checker_mode_engine_if;
    import checker_mode_engine_pkg::*;

    logic [MODE_W-1:0] mode_mode;
    logic              mode_start;
    logic [ADDR_W-1:0] mode_addr;
    logic              mode_end;
    logic [DATA_W-1:0] mode_data;
    logic              mode_irq;
    logic              mode_ack;
    logic              mode_error;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic              mem_err;

    modport master (
        output mode_mode, mode_start, mode_addr, mode_ack,
        output mem_ack, mem_data, mem_err,
        input  mode_end, mode_data, mode_irq, mode_error,
        input  mem_req, mem_addr
    );

    modport slave (
        input  mode_mode, mode_start, mode_addr, mode_ack,
        input  mem_ack, mem_data, mem_err,
        output mode_end, mode_data, mode_irq, mode_error,
        output mem_req, mem_addr
    );

endinterface

// File: rtl/checker_mode_engine_timeout.sv
// checker_mode_timeout: loadable down-counter shared by the DUMMY wait and
// the read timeout. load has priority over clear, clear over dec.
// Ports: clk, rst_n, clear, load, load_val, dec, expired_c (count == 0).
module checker_mode_timeout
    import checker_mode_engine_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expired_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/checker_mode_engine.sv
// checker_mode_engine: responder side of the checker mode interface.
// Launches NONE/DUMMY/READ/IRQ operations on a rising edge of mode_start,
// aborts on a low level, and drives a single-outstanding memory read port.
// Ports: sys_clk, sys_rst_n (async active-low), bus (checker_mode_engine_if.slave).
// Optional IRQ polling mode is built when CHECKER_MODE_IRQ_EN is defined;
// otherwise mode 3 takes the error path and mode_irq is tied low.
// DUMMY_CYCLES and TIMEOUT must lie in 1..256 (8-bit counter).
module checker_mode_engine
    import checker_mode_engine_pkg::*;
#(
    parameter int unsigned DUMMY_CYCLES = 8,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    checker_mode_engine_if.slave  bus
);

    checker_state_e    state_q, state_d;
    logic              start_q;
    mode_cmd_t         cmd_q, cmd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              end_q, end_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;

    logic              start_edge_c;
    logic              tmr_clear, tmr_load, tmr_dec, tmr_exp_c;
    logic [CNT_W-1:0]  tmr_val;

`ifdef CHECKER_MODE_IRQ_EN
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] ref_q, ref_d;
    logic              ref_vld_q, ref_vld_d;
`else
    logic              unused_mode_ack;
    assign unused_mode_ack = bus.mode_ack;
`endif

    assign start_edge_c = bus.mode_start & ~start_q;

    checker_mode_timeout u_timeout (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .clear     (tmr_clear),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .dec       (tmr_dec),
        .expired_c (tmr_exp_c)
    );

    // State and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            cmd_q     <= '0;
            data_q    <= '0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
            req_q     <= 1'b0;
            maddr_q   <= '0;
`ifdef CHECKER_MODE_IRQ_EN
            irq_q     <= 1'b0;
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            start_q   <= bus.mode_start;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            end_q     <= end_d;
            err_q     <= err_d;
            req_q     <= req_d;
            maddr_q   <= maddr_d;
`ifdef CHECKER_MODE_IRQ_EN
            irq_q     <= irq_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
`endif
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        end_d     = 1'b0;
        err_d     = 1'b0;
        // A request is always retired by its ack, whatever the state does.
        req_d     = req_q & ~bus.mem_ack;
        maddr_d   = maddr_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
`ifdef CHECKER_MODE_IRQ_EN
        irq_d     = irq_q;
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_edge_c) begin
                    cmd_d.mode = checker_mode_e'(bus.mode_mode);
                    cmd_d.addr = bus.mode_addr;
                    data_d     = '0;
                    case (checker_mode_e'(bus.mode_mode))
                        CHECKER_MODE_DUMMY: begin
                            tmr_load = 1'b1;
                            tmr_val  = CNT_W'(DUMMY_CYCLES - 1);
                            state_d  = ST_DUMMY;
                        end
                        CHECKER_MODE_READ: begin
                            req_d   = 1'b1;
                            maddr_d = bus.mode_addr;
                            state_d = ST_RD_REQ;
                        end
`ifdef CHECKER_MODE_IRQ_EN
                        CHECKER_MODE_IRQ: begin
                            req_d     = 1'b1;
                            maddr_d   = bus.mode_addr;
                            ref_vld_d = 1'b0;
                            state_d   = ST_RD_REQ;
                        end
`endif
                        default: begin
                            end_d   = 1'b1;
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end

            ST_DUMMY: begin
                if (!bus.mode_start) begin
                    state_d = ST_IDLE;
                end else if (tmr_exp_c) begin
                    data_d  = ~cmd_q.addr;
                    end_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_RD_REQ, ST_RD_WAIT: begin
                if (!bus.mode_start) begin
                    // Abort: drain an open request in DONE, else straight to IDLE.
                    state_d = bus.mem_ack ? ST_IDLE : ST_DONE;
                end else if (bus.mem_ack) begin
                    if (bus.mem_err) begin
                        data_d  = '0;
                        end_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (cmd_q.mode == CHECKER_MODE_READ) begin
                        data_d  = bus.mem_data;
                        end_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
`ifdef CHECKER_MODE_IRQ_EN
                        if (ref_vld_q && (bus.mem_data != ref_q)) begin
                            data_d  = bus.mem_data;
                            irq_d   = 1'b1;
                            state_d = ST_IRQ_WAIT;
                        end else begin
                            // First word becomes the reference; re-read back-to-back.
                            ref_d     = ref_vld_q ? ref_q : bus.mem_data;
                            ref_vld_d = 1'b1;
                            req_d     = 1'b1;
                            state_d   = ST_RD_REQ;
                        end
`else
                        data_d  = '0;
                        end_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
`endif
                    end
                end else if (state_q == ST_RD_REQ) begin
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(TIMEOUT - 1);
                    state_d  = ST_RD_WAIT;
                end else if (tmr_exp_c) begin
                    // Timeout: request stays open; its late ack is swallowed in DONE.
                    data_d  = '0;
                    end_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

`ifdef CHECKER_MODE_IRQ_EN
            ST_IRQ_WAIT: begin
                if (!bus.mode_start) begin
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (bus.mode_ack) begin
                    irq_d   = 1'b0;
                    end_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                if (!bus.mode_start && (!req_q || bus.mem_ack)) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tmr_clear = (state_d == ST_IDLE);
    end

    assign bus.mode_end   = end_q;
    assign bus.mode_error = err_q;
    assign bus.mode_data  = data_q;
    assign bus.mem_req    = req_q;
    assign bus.mem_addr   = maddr_q;
`ifdef CHECKER_MODE_IRQ_EN
    assign bus.mode_irq   = irq_q;
`else
    assign bus.mode_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_checker_mode_engine.sv
// Directed bench for checker_mode_engine: a table of per-cycle vectors for the
// READ / invalid-mode / abort paths, plus hand sequences for DUMMY timing,
// DUMMY abort, read timeout, IRQ polling and asynchronous reset.
module tb_checker_mode_engine;

    localparam int unsigned DC = 8;
    localparam int unsigned TO = 16;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    checker_mode_engine_if bus ();

    checker_mode_engine #(
        .DUMMY_CYCLES (DC),
        .TIMEOUT      (TO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        start;
        logic [1:0]  mode;
        logic [63:0] addr;
        logic        ack;
        logic [63:0] rdata;
        logic        rerr;
        logic        e_end;
        logic        e_err;
        logic [63:0] e_data;
        logic        e_req;
        logic [63:0] e_maddr;
    } vec_t;

    vec_t vecs[$];
    logic [63:0] irq_words[4];

    function automatic vec_t mk(input logic s, input logic [1:0] m, input logic [63:0] a,
                                input logic k, input logic [63:0] rd, input logic re,
                                input logic ee, input logic er, input logic [63:0] ed,
                                input logic eq, input logic [63:0] ema);
        vec_t v;
        v.start = s;   v.mode = m;    v.addr = a;
        v.ack   = k;   v.rdata = rd;  v.rerr = re;
        v.e_end = ee;  v.e_err = er;  v.e_data = ed;
        v.e_req = eq;  v.e_maddr = ema;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic clear_inputs();
        bus.mode_mode  = 2'd0;
        bus.mode_start = 1'b0;
        bus.mode_addr  = '0;
        bus.mode_ack   = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.mem_data   = '0;
        bus.mem_err    = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_end"},   64'(bus.mode_end),   64'd0);
        chk({tag, "_err"},   64'(bus.mode_error), 64'd0);
        chk({tag, "_data"},  bus.mode_data,       64'd0);
        chk({tag, "_irq"},   64'(bus.mode_irq),   64'd0);
        chk({tag, "_req"},   64'(bus.mem_req),    64'd0);
        chk({tag, "_maddr"}, bus.mem_addr,        64'd0);
    endtask

    initial begin
        // start  mode addr  ack rdata rerr | end err data req maddr
        vecs.push_back(mk(1, 2, 64'h1000, 0, 0, 0,  0, 0, 64'h0, 1, 64'h1000));
        vecs.push_back(mk(1, 2, 64'h1000, 0, 0, 0,  0, 0, 64'h0, 1, 64'h1000));
        vecs.push_back(mk(1, 2, 64'h1000, 0, 0, 0,  0, 0, 64'h0, 1, 64'h1000));
        vecs.push_back(mk(1, 2, 64'h1000, 1, 64'hdeadbeef_cafef00d, 0,
                          1, 0, 64'hdeadbeef_cafef00d, 0, 0));
        vecs.push_back(mk(1, 2, 64'h1000, 0, 0, 0,  0, 0, 64'hdeadbeef_cafef00d, 0, 0));
        vecs.push_back(mk(1, 2, 64'h1000, 0, 0, 0,  0, 0, 64'hdeadbeef_cafef00d, 0, 0));
        vecs.push_back(mk(0, 2, 64'h1000, 0, 0, 0,  0, 0, 64'hdeadbeef_cafef00d, 0, 0));
        // invalid mode 0
        vecs.push_back(mk(1, 0, 64'h5,    0, 0, 0,  1, 1, 64'h0, 0, 0));
        vecs.push_back(mk(1, 0, 64'h5,    0, 0, 0,  0, 0, 64'h0, 0, 0));
        vecs.push_back(mk(0, 0, 64'h5,    0, 0, 0,  0, 0, 64'h0, 0, 0));
        // read with bus error
        vecs.push_back(mk(1, 2, 64'h2000, 0, 0, 0,  0, 0, 64'h0, 1, 64'h2000));
        vecs.push_back(mk(1, 2, 64'h2000, 1, 64'hffff, 1,  1, 1, 64'h0, 0, 0));
        vecs.push_back(mk(0, 2, 64'h2000, 0, 0, 0,  0, 0, 64'h0, 0, 0));
        // abort coincident with mem_ack
        vecs.push_back(mk(1, 2, 64'h3000, 0, 0, 0,  0, 0, 64'h0, 1, 64'h3000));
        vecs.push_back(mk(0, 2, 64'h3000, 1, 64'h1234, 0,  0, 0, 64'h0, 0, 0));
        vecs.push_back(mk(0, 2, 64'h3000, 0, 0, 0,  0, 0, 64'h0, 0, 0));
        // abort with request outstanding, drain then new read
        vecs.push_back(mk(1, 2, 64'h4000, 0, 0, 0,  0, 0, 64'h0, 1, 64'h4000));
        vecs.push_back(mk(0, 2, 64'h4000, 0, 0, 0,  0, 0, 64'h0, 1, 64'h4000));
        vecs.push_back(mk(0, 2, 64'h4000, 0, 0, 0,  0, 0, 64'h0, 1, 64'h4000));
        vecs.push_back(mk(0, 2, 64'h4000, 1, 64'h99, 0,  0, 0, 64'h0, 0, 0));
        vecs.push_back(mk(1, 2, 64'h5000, 0, 0, 0,  0, 0, 64'h0, 1, 64'h5000));
        vecs.push_back(mk(1, 2, 64'h5000, 1, 64'h55, 0,  1, 0, 64'h55, 0, 0));
        vecs.push_back(mk(0, 2, 64'h5000, 0, 0, 0,  0, 0, 64'h55, 0, 0));

        irq_words[0] = 64'd5;
        irq_words[1] = 64'd5;
        irq_words[2] = 64'd5;
        irq_words[3] = 64'd7;

        // Reset state
        clear_inputs();
        sys_rst_n = 1'b0;
        repeat (2) tick();
        chk_all_zero("reset");
        sys_rst_n = 1'b1;
        tick();

        // Table-driven vectors
        foreach (vecs[i]) begin
            bus.mode_start = vecs[i].start;
            bus.mode_mode  = vecs[i].mode;
            bus.mode_addr  = vecs[i].addr;
            bus.mem_ack    = vecs[i].ack;
            bus.mem_data   = vecs[i].rdata;
            bus.mem_err    = vecs[i].rerr;
            tick();
            chk($sformatf("vec%0d_end", i),  64'(bus.mode_end),   64'(vecs[i].e_end));
            chk($sformatf("vec%0d_err", i),  64'(bus.mode_error), 64'(vecs[i].e_err));
            chk($sformatf("vec%0d_data", i), bus.mode_data,       vecs[i].e_data);
            chk($sformatf("vec%0d_req", i),  64'(bus.mem_req),    64'(vecs[i].e_req));
            chk($sformatf("vec%0d_irq", i),  64'(bus.mode_irq),   64'd0);
            if (vecs[i].e_req)
                chk($sformatf("vec%0d_maddr", i), bus.mem_addr, vecs[i].e_maddr);
        end
        clear_inputs();
        tick();

        // DUMMY: edge at cycle 0, mode_end only at cycle 9
        bus.mode_mode  = 2'd1;
        bus.mode_addr  = 64'haaaaaaaa_bbbbbbbb;
        bus.mode_start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("dummy_end_c%0d", c), 64'(bus.mode_end),   64'(c == 9));
            chk($sformatf("dummy_err_c%0d", c), 64'(bus.mode_error), 64'd0);
            if (c == 9)
                chk("dummy_data", bus.mode_data, 64'h55555555_44444444);
        end
        bus.mode_start = 1'b0;
        tick();

        // DUMMY abort at count 3, then a fresh full-length run
        bus.mode_mode  = 2'd1;
        bus.mode_addr  = 64'h1234;
        bus.mode_start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("abort_pre_end_c%0d", c), 64'(bus.mode_end), 64'd0);
        end
        bus.mode_start = 1'b0;
        for (int c = 5; c <= 12; c++) begin
            tick();
            chk($sformatf("abort_post_end_c%0d", c), 64'(bus.mode_end), 64'd0);
        end
        bus.mode_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk($sformatf("restart_end_c%0d", c), 64'(bus.mode_end), 64'(c == 9));
            if (c == 9)
                chk("restart_data", bus.mode_data, ~64'h1234);
        end
        bus.mode_start = 1'b0;
        tick();

        // READ timeout: mem_req rises at cycle 1, end+error at cycle 18
        bus.mode_mode  = 2'd2;
        bus.mode_addr  = 64'h6000;
        bus.mode_start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            chk($sformatf("to_end_c%0d", c), 64'(bus.mode_end),   64'(c == 18));
            chk($sformatf("to_err_c%0d", c), 64'(bus.mode_error), 64'(c == 18));
            chk($sformatf("to_req_c%0d", c), 64'(bus.mem_req),    64'd1);
            if (c == 1)  chk("to_maddr", bus.mem_addr, 64'h6000);
            if (c == 18) chk("to_data", bus.mode_data, 64'd0);
        end
        bus.mem_ack  = 1'b1;
        bus.mem_data = 64'habc;
        tick();
        bus.mem_ack  = 1'b0;
        chk("late_ack_req", 64'(bus.mem_req),  64'd0);
        chk("late_ack_end", 64'(bus.mode_end), 64'd0);
        chk("late_ack_err", 64'(bus.mode_error), 64'd0);
        tick();
        chk("late_ack_end2", 64'(bus.mode_end), 64'd0);
        bus.mode_start = 1'b0;
        repeat (2) tick();

`ifdef CHECKER_MODE_IRQ_EN
        // IRQ polling: 5,5,5,7 -> irq with data 7, then mode_ack ends
        begin
            int  reads;
            bit  seen;
            reads = 0;
            seen  = 1'b0;
            bus.mode_mode  = 2'd3;
            bus.mode_addr  = 64'h7000;
            bus.mode_start = 1'b1;
            for (int c = 0; c < 60 && !seen; c++) begin
                tick();
                bus.mem_ack = 1'b0;
                if (bus.mode_irq) begin
                    seen = 1'b1;
                end else if (bus.mem_req && reads < 4) begin
                    bus.mem_ack  = 1'b1;
                    bus.mem_data = irq_words[reads];
                    reads++;
                end
            end
            bus.mem_ack = 1'b0;
            chk("irq_seen", 64'(seen), 64'd1);
            chk("irq_reads", 64'(reads), 64'd4);
            chk("irq_data", bus.mode_data, 64'd7);
            chk("irq_end_early", 64'(bus.mode_end), 64'd0);
            tick();
            chk("irq_held", 64'(bus.mode_irq), 64'd1);
            bus.mode_ack = 1'b1;
            tick();
            bus.mode_ack = 1'b0;
            chk("irq_fall", 64'(bus.mode_irq), 64'd0);
            chk("irq_end", 64'(bus.mode_end), 64'd1);
            chk("irq_end_err", 64'(bus.mode_error), 64'd0);
            tick();
            chk("irq_end_once", 64'(bus.mode_end), 64'd0);
            bus.mode_start = 1'b0;
            tick();
        end
`else
        // Mode 3 without IRQ support takes the error path
        bus.mode_mode  = 2'd3;
        bus.mode_addr  = 64'h7000;
        bus.mode_start = 1'b1;
        tick();
        chk("m3_end", 64'(bus.mode_end),   64'd1);
        chk("m3_err", 64'(bus.mode_error), 64'd1);
        chk("m3_req", 64'(bus.mem_req),    64'd0);
        chk("m3_irq", 64'(bus.mode_irq),   64'd0);
        tick();
        chk("m3_end_once", 64'(bus.mode_end), 64'd0);
        bus.mode_start = 1'b0;
        tick();
`endif

        // Asynchronous reset mid-read
        bus.mode_mode  = 2'd2;
        bus.mode_addr  = 64'h8000;
        bus.mode_start = 1'b1;
        repeat (2) tick();
        chk("rst_pre_req", 64'(bus.mem_req), 64'd1);
        #2 sys_rst_n = 1'b0;
        #1 chk_all_zero("rst_async");
        bus.mode_start = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        repeat (2) tick();
        chk("rst_post_req", 64'(bus.mem_req),  64'd0);
        chk("rst_post_end", 64'(bus.mode_end), 64'd0);
        bus.mode_mode  = 2'd0;
        bus.mode_start = 1'b1;
        tick();
        chk("rst_idle_end", 64'(bus.mode_end),   64'd1);
        chk("rst_idle_err", 64'(bus.mode_error), 64'd1);
        bus.mode_start = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/checker_mode_engine.md
# checker_mode_engine

Responder side of the checker mode interface: accepts the mode, start level and 64-bit address driven by the checker control interface, executes the selected check mode, and returns end, data, IRQ and error indications. It sits between the control interface and a simple 64-bit request/acknowledge memory read port, one instance per checker.

## Interface

Parameters:
- DUMMY_CYCLES, 8: cycles the DUMMY mode waits before ending (≥1).
- TIMEOUT, 255: maximum cycles waited for mem_ack before an error is flagged (≥1).

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset; one clock, asynchronous and active-low.
- mode_mode  in  2  mode code, sampled on the start edge.
- mode_start  in  1  level; a rising edge launches an operation, and a low level aborts it.
- mode_addr  in  64  target address, sampled on the start edge.
- mode_end  out  1  one-cycle pulse when an operation completes, including on error.
- mode_data  out  64  result; valid from the mode_end cycle and held until the next start edge.
- mode_irq  out  1  level IRQ request (IRQ mode only).
- mode_ack  in  1  one-cycle pulse acknowledging mode_irq.
- mode_error  out  1  one-cycle pulse, coincident with mode_end, on failure.
- mem_req  out  1  read request, held until mem_ack.
- mem_addr  out  64  read address; stable while mem_req is high.
- mem_ack  in  1  one-cycle read completion.
- mem_data  in  64  read data, valid with mem_ack.
- mem_err  in  1  bus error, valid with mem_ack.

## Operation

Mode codes:
- 0 IDLE/NONE: the engine ends immediately with mode_error.
- 1 DUMMY: wait DUMMY_CYCLES, then return ~addr.
- 2 READ: perform one bus read and return the word.
- 3 IRQ: poll until the word changes, raise the IRQ, then end (see Configuration).

State machine states: IDLE, DUMMY, RD_REQ, RD_WAIT, IRQ_WAIT, DONE.

Transitions:
- IDLE→dispatch: on start_edge = mode_start & ~start_q. mode and addr are latched, and mode_data is cleared on this edge.
- DUMMY: the counter runs from 0 to DUMMY_CYCLES-1, then the engine pulses mode_end with mode_data = ~addr_latched and goes to DONE.
- RD_REQ/RD_WAIT: mem_req=1 with mem_addr=addr_latched until mem_ack.
  - On mem_ack with mem_err=0: mode_data=mem_data, pulse mode_end, go to DONE.
  - On mem_err=1 or timeout: mode_data=0, pulse mode_end and mode_error, go to DONE.
- Timeout: an 8-bit counter that resets on entry to RD_WAIT. Timeout fires when the counter reaches TIMEOUT. If the request is still open when timeout fires, mem_req stays asserted until mem_ack arrives. That late ack is discarded and produces no second mode_end.
- DONE: the engine stays here until mode_start=0, then returns to IDLE. A new operation always needs a fresh rising edge.
- Invalid mode (0, or 3 when IRQ mode is excluded): mode_end and mode_error pulse together in the cycle after the start edge. mode_data=0.

Abort (mode_start=0 in any busy state):
- The operation is dropped, mode_irq clears, and no mode_end is produced.
- If mem_req is outstanding, the engine waits for mem_ack, discards the result, then goes to IDLE.

Simultaneous events:
- mem_ack in the same cycle as the abort: the result is discarded.
- mode_ack while mode_irq=0: ignored.

## Timing

- Reset values: mode_end=0, mode_data=0, mode_irq=0, mode_error=0, mem_req=0, mem_addr=0. State=IDLE, start_q=0.
- The start edge is detected registered. For a rising edge at cycle N, state leaves IDLE at N+1.
- DUMMY: mode_end is high in cycle N+1+DUMMY_CYCLES.
- READ: mem_req rises at N+1. For mem_ack at cycle M, mode_end and mode_data are valid at M+1.
- mode_irq rises the cycle after the change is detected and falls the cycle after mode_ack. mode_end follows in that same cycle.

## Configuration

CHECKER_MODE_IRQ_EN:
- Defined: mode 3 reads the address once (reference word), then re-reads back-to-back. The first read whose word differs from the reference sets mode_data to the new word, raises mode_irq, and enters IRQ_WAIT. On mode_ack, mode_irq clears and mode_end pulses.
- Bus error or timeout during polling: mode_error and mode_end pulse, and mode_irq is never raised.
- Undefined: mode 3 is invalid (error path). mode_irq is tied to 0, mode_ack is ignored, and the IRQ_WAIT logic is not built.

## Structure

- Mode codes CHECKER_MODE_NONE/DUMMY/READ/IRQ and the state encodings belong in the shared checker.vh.
- One sub-module, checker_mode_timeout: a loadable down-counter with clear, load and expired signals, reused for both the DUMMY wait and the read timeout.

## Test plan

- DUMMY, addr=0xaaaaaaaa_bbbbbbbb, DUMMY_CYCLES=8, start edge at cycle 0 → mode_end high only at cycle 9, mode_data=0x55555555_44444444, mode_error=0.
- READ, addr=0x1000, mem_ack after 3 cycles with data 0xdeadbeef_cafef00d → mem_addr=0x1000, then mode_end with that data. Without a start low/high edge, no second operation.
- READ with no mem_ack, TIMEOUT=16 → mode_end and mode_error pulse 17 cycles after mem_req rises. A late ack produces no further pulse.
- Abort: mode_start drops during DUMMY at count 3 → no mode_end, state IDLE. Re-raising mode_start starts fresh with the full 8-cycle wait.
- IRQ mode (macro defined): memory returns 5, 5, 5, 7 → mode_irq rises after the fourth read with mode_data=7. mode_ack → mode_irq falls and mode_end pulses. Macro undefined: immediate mode_error.
- Reset asserted mid-read with mem_req high → all outputs 0 asynchronously, state IDLE after release.
